codificador_de_instrucoes: RTL and testbench



---
 rtl/codificador_de_instrucoes.sv | 181 ++++++++++++++++++
 tb/tb_codificador_de_instrucoes.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codificador_de_instrucoes.sv
// Instruction encoder / program loader: one symbolic instruction per handshake in, one 32-bit word written to instruction memory.
// Optional define CODIFICADOR_VERIFICA_IMM_EN enables immediate range/alignment checking before the write.
module codificador_de_instrucoes #(
    parameter logic [31:0] BASE = 32'h0000_0000,
    parameter int          PROF = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inicio,
    input  logic                   fim,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             op,
    input  logic [4:0]             rd,
    input  logic [4:0]             rs1,
    input  logic [4:0]             rs2,
    input  logic [31:0]            imm,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [$clog2(PROF):0]  num_instr,
    output logic                   cheio,
    output logic                   erro,
    output logic [1:0]             erro_cod,
    output logic [1:0]             estado_dbg
);

    localparam int CW = $clog2(PROF) + 1;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ATIVO  = 2'd1,
        CHEIO  = 2'd2,
        ERRO   = 2'd3
    } estado_t;

    typedef enum logic [2:0] {
        F_R, F_I, F_S, F_B, F_J, F_U, F_ILEGAL
    } formato_t;

    localparam logic [1:0] COD_OK        = 2'd0;
    localparam logic [1:0] COD_ILEGAL    = 2'd1;
    localparam logic [1:0] COD_FAIXA     = 2'd2;
    localparam logic [1:0] COD_DESALINHO = 2'd3;

    estado_t    estado;
    formato_t   fmt;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] palavra;
    logic [1:0]  falha;
    logic        transfer;
    logic        ultimo;

    // Handshake: a transfer happens on a rising edge where in_valid && in_ready;
    // in_ready depends only on state, and fields are sampled on that edge.
    assign in_ready   = (estado == ATIVO);
    assign transfer   = in_valid && in_ready;
    assign estado_dbg = estado;
    assign ultimo     = (num_instr == CW'(PROF - 1));

    always_comb begin
        fmt = F_ILEGAL;
        opc = 7'd0;
        f3  = 3'd0;
        f7  = 7'd0;
        case (op)
            5'd0:  begin fmt = F_R; opc = 7'd51;                      end
            5'd1:  begin fmt = F_R; opc = 7'd51; f7 = 7'd32;          end
            5'd2:  begin fmt = F_R; opc = 7'd51; f3 = 3'd1;           end
            5'd3:  begin fmt = F_R; opc = 7'd51; f3 = 3'd2;           end
            5'd4:  begin fmt = F_R; opc = 7'd51; f3 = 3'd3;           end
            5'd5:  begin fmt = F_R; opc = 7'd51; f3 = 3'd3; f7 = 7'd32; end
            5'd6:  begin fmt = F_R; opc = 7'd51; f3 = 3'd4;           end
            5'd7:  begin fmt = F_R; opc = 7'd51; f3 = 3'd4; f7 = 7'd32; end
            5'd8:  begin fmt = F_R; opc = 7'd51; f3 = 3'd5;           end
            5'd9:  begin fmt = F_R; opc = 7'd51; f3 = 3'd6;           end
            5'd10: begin fmt = F_R; opc = 7'd51; f3 = 3'd7;           end
            5'd11: begin fmt = F_I; opc = 7'd3;  f3 = 3'd2;           end
            5'd12: begin fmt = F_I; opc = 7'd19;                      end
            5'd13: begin fmt = F_B; opc = 7'd99;                      end
            5'd14: begin fmt = F_B; opc = 7'd99; f3 = 3'd1;           end
            5'd15: begin fmt = F_B; opc = 7'd99; f3 = 3'd4;           end
            5'd16: begin fmt = F_B; opc = 7'd99; f3 = 3'd5;           end
            5'd17: begin fmt = F_J; opc = 7'd111;                     end
            5'd18: begin fmt = F_S; opc = 7'd35; f3 = 3'd2;           end
            5'd19: begin fmt = F_U; opc = 7'd55;                      end
            default: fmt = F_ILEGAL;
        endcase
    end

    always_comb begin
        palavra = 32'd0;
        case (fmt)
            F_R: palavra = {f7, rs2, rs1, f3, rd, opc};
            F_I: palavra = {imm[11:0], rs1, f3, rd, opc};
            F_S: palavra = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
            F_B: palavra = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
            F_J: palavra = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
            F_U: palavra = {imm[31:12], rd, opc};
            default: palavra = 32'd0;
        endcase
    end

    // A value fits an N-bit signed field when all bits from N-1 upward agree.
    always_comb begin
        falha = COD_OK;
        if (fmt == F_ILEGAL) begin
            falha = COD_ILEGAL;
        end
`ifdef CODIFICADOR_VERIFICA_IMM_EN
        else begin
            case (fmt)
                F_I, F_S: begin
                    if (!((&imm[31:11]) || !(|imm[31:11])))
                        falha = COD_FAIXA;
                end
                F_B: begin
                    if (!((&imm[31:12]) || !(|imm[31:12])))
                        falha = COD_FAIXA;
                    else if (imm[0])
                        falha = COD_DESALINHO;
                end
                F_J: begin
                    if (!((&imm[31:20]) || !(|imm[31:20])))
                        falha = COD_FAIXA;
                    else if (imm[0])
                        falha = COD_DESALINHO;
                end
                default: falha = COD_OK;
            endcase
        end
`endif
    end

    // inicio has priority over everything else, including a transfer in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= OCIOSO;
            mem_we    <= 1'b0;
            mem_addr  <= BASE;
            mem_wdata <= 32'd0;
            num_instr <= '0;
            cheio     <= 1'b0;
            erro      <= 1'b0;
            erro_cod  <= 2'd0;
        end else begin
            mem_we <= 1'b0;
            if (inicio) begin
                estado    <= ATIVO;
                num_instr <= '0;
                cheio     <= 1'b0;
                erro      <= 1'b0;
                erro_cod  <= 2'd0;
            end else if (estado == ATIVO) begin
                if (transfer) begin
                    if (falha != COD_OK) begin
                        estado   <= ERRO;
                        erro     <= 1'b1;
                        erro_cod <= falha;
                    end else begin
                        mem_we    <= 1'b1;
                        mem_addr  <= BASE + (32'(num_instr) << 2);
                        mem_wdata <= palavra;
                        num_instr <= num_instr + CW'(1);
                        if (ultimo) begin
                            estado <= CHEIO;
                            cheio  <= 1'b1;
                        end else if (fim) begin
                            estado <= OCIOSO;
                        end
                    end
                end else if (fim) begin
                    estado <= OCIOSO;
                end
            end
        end
    end

endmodule

// File: tb/tb_codificador_de_instrucoes.sv
// Self-checking bench for codificador_de_instrucoes: reference encoder model, expected-write queue, end report.
module tb_codificador_de_instrucoes;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          PROF = 4;
    localparam int          CW   = $clog2(PROF) + 1;

    logic          clk;
    logic          rst;
    logic          inicio;
    logic          fim;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    op;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [31:0]   imm;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [CW-1:0] num_instr;
    logic          cheio;
    logic          erro;
    logic [1:0]    erro_cod;
    logic [1:0]    estado_dbg;

    codificador_de_instrucoes #(.BASE(BASE), .PROF(PROF)) dut (
        .clk(clk), .rst(rst), .inicio(inicio), .fim(fim),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .num_instr(num_instr), .cheio(cheio), .erro(erro),
        .erro_cod(erro_cod), .estado_dbg(estado_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    int          mdl_cnt = 0;
    bit          mdl_ativo = 0;
    bit          mdl_erro = 0;
    bit          mdl_cheio = 0;
    logic [1:0]  mdl_cod = 2'd0;
    int          bnd[12] = '{2047, -2048, 2048, -2049, 4094, 4095, -4096, -4098,
                             1048574, 1048576, -1048576, 3};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference encoder, built from shifts and masks of the field values
    function automatic void encode(input logic [4:0] o, d, s1, s2, input logic [31:0] i,
                                   output logic [31:0] w, output logic [1:0] c);
        int          si;
        int          kind;
        logic [31:0] f3, f7, opc;
        si = $signed(i);
        c = 2'd0; w = 32'd0; f3 = 0; f7 = 0; opc = 0; kind = 6;
        case (o)
            5'd0:  kind = 0;
            5'd1:  begin kind = 0; f7 = 32; end
            5'd2:  begin kind = 0; f3 = 1; end
            5'd3:  begin kind = 0; f3 = 2; end
            5'd4:  begin kind = 0; f3 = 3; end
            5'd5:  begin kind = 0; f3 = 3; f7 = 32; end
            5'd6:  begin kind = 0; f3 = 4; end
            5'd7:  begin kind = 0; f3 = 4; f7 = 32; end
            5'd8:  begin kind = 0; f3 = 5; end
            5'd9:  begin kind = 0; f3 = 6; end
            5'd10: begin kind = 0; f3 = 7; end
            5'd11: begin kind = 1; opc = 3; f3 = 2; end
            5'd12: begin kind = 1; opc = 19; end
            5'd13: kind = 3;
            5'd14: begin kind = 3; f3 = 1; end
            5'd15: begin kind = 3; f3 = 4; end
            5'd16: begin kind = 3; f3 = 5; end
            5'd17: kind = 4;
            5'd18: begin kind = 2; f3 = 2; end
            5'd19: kind = 5;
            default: kind = 6;
        endcase
        if (kind == 6) c = 2'd1;
`ifdef CODIFICADOR_VERIFICA_IMM_EN
        else if ((kind == 1 || kind == 2) && (si < -2048 || si > 2047)) c = 2'd2;
        else if (kind == 3 && (si < -4096 || si > 4095)) c = 2'd2;
        else if (kind == 3 && i[0]) c = 2'd3;
        else if (kind == 4 && (si < -1048576 || si > 1048575)) c = 2'd2;
        else if (kind == 4 && i[0]) c = 2'd3;
`endif
        case (kind)
            0: w = (f7 << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (f3 << 12) | (32'(d) << 7) | 32'd51;
            1: w = ((i & 32'hfff) << 20) | (32'(s1) << 15) | (f3 << 12) | (32'(d) << 7) | opc;
            2: w = (((i >> 5) & 32'h7f) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (f3 << 12)
                   | ((i & 32'h1f) << 7) | 32'd35;
            3: w = (((i >> 12) & 1) << 31) | (((i >> 5) & 32'h3f) << 25) | (32'(s2) << 20)
                   | (32'(s1) << 15) | (f3 << 12) | (((i >> 1) & 32'hf) << 8)
                   | (((i >> 11) & 1) << 7) | 32'd99;
            4: w = (((i >> 20) & 1) << 31) | (((i >> 1) & 32'h3ff) << 21) | (((i >> 11) & 1) << 20)
                   | (((i >> 12) & 32'hff) << 12) | (32'(d) << 7) | 32'd111;
            5: w = (i & 32'hffff_f000) | (32'(d) << 7) | 32'd55;
            default: w = 32'd0;
        endcase
    endfunction

    // scoreboard: every write the DUT makes must match the head of the queue
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("extra_write", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("mem_addr", mem_addr, mon_e[63:32]);
                check("mem_wdata", mem_wdata, mon_e[31:0]);
            end
        end
    end

    // driver tasks; each is entered and left 1 time unit after a rising edge
    task automatic start();
        inicio = 1'b1;
        @(posedge clk); #1;
        inicio = 1'b0;
        mdl_ativo = 1; mdl_cnt = 0; mdl_erro = 0; mdl_cod = 2'd0; mdl_cheio = 0;
        check("rdy_after_inicio", in_ready, 1);
        check("num_after_inicio", num_instr, 0);
        check("erro_after_inicio", erro, 0);
        check("cod_after_inicio", erro_cod, 0);
    endtask

    task automatic send(input logic [4:0] o, d, s1, s2, input logic [31:0] i, input bit with_fim);
        logic [31:0] w;
        logic [1:0]  c;
        bit          wr;
        op = o; rd = d; rs1 = s1; rs2 = s2; imm = i;
        in_valid = 1'b1; fim = with_fim;
        check("in_ready", in_ready, mdl_ativo);
        wr = 0;
        if (mdl_ativo) begin
            encode(o, d, s1, s2, i, w, c);
            if (c != 2'd0) begin
                mdl_ativo = 0; mdl_erro = 1; mdl_cod = c;
            end else begin
                exp_q.push_back({BASE + 32'(mdl_cnt) * 4, w});
                wr = 1;
                mdl_cnt++;
                if (mdl_cnt == PROF) begin
                    mdl_ativo = 0; mdl_cheio = 1;
                end
            end
            if (with_fim) mdl_ativo = 0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; fim = 1'b0;
        check("mem_we", mem_we, wr);
        check("num_instr", num_instr, mdl_cnt);
        check("erro", erro, mdl_erro);
        check("erro_cod", erro_cod, mdl_cod);
        check("cheio", cheio, mdl_cheio);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, BASE);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_num"}, num_instr, 0);
        check({tag, "_cheio"}, cheio, 0);
        check({tag, "_erro"}, erro, 0);
        check({tag, "_cod"}, erro_cod, 0);
    endtask

    initial begin
        logic [4:0]  ro;
        logic [31:0] ri;
        rst = 1'b1; inicio = 1'b0; fim = 1'b0; in_valid = 1'b0;
        op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst0");
        rst = 1'b0;
        @(posedge clk); #1;

        // single add
        start();
        send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0);
        check("vec_add", mem_wdata, 32'h002081B3);
        check("vec_add_addr", mem_addr, BASE);

        // back-to-back sub then beq
        start();
        send(5'd1, 5'd5, 5'd6, 5'd7, 32'd0, 0);
        check("vec_sub", mem_wdata, 32'h407302B3);
        send(5'd13, 5'd0, 5'd1, 5'd2, 32'd8, 0);
        check("vec_beq", mem_wdata, 32'h00208463);
        check("vec_beq_addr", mem_addr, BASE + 32'd4);

        // capacity: five offered, four accepted
        start();
        for (int k = 0; k < 5; k++)
            send(5'($urandom_range(0, 10)), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 0);
        check("full_cheio", cheio, 1);
        check("full_ready", in_ready, 0);
        check("full_num", num_instr, PROF);

        // illegal op and recovery
        start();
        send(5'd25, 5'd1, 5'd2, 5'd3, 32'd0, 0);
        check("illegal_erro", erro, 1);
        check("illegal_cod", erro_cod, 1);
        start();

        // immediate handling
        start();
        send(5'd12, 5'd0, 5'd0, 5'd0, 32'd4096, 0);
`ifdef CODIFICADOR_VERIFICA_IMM_EN
        check("addi_range_cod", erro_cod, 2);
        start();
        send(5'd17, 5'd1, 5'd0, 5'd0, 32'd3, 0);
        check("jal_align_cod", erro_cod, 3);
`else
        check("addi_trunc", mem_wdata, 32'h00000013);
`endif

        // fim together with a transfer, then fim alone, then inicio+fim
        start();
        send(5'd6, 5'd1, 5'd2, 5'd3, 32'd0, 1);
        send(5'd9, 5'd1, 5'd2, 5'd3, 32'd0, 0);
        start();
        fim = 1'b1;
        @(posedge clk); #1;
        fim = 1'b0; mdl_ativo = 0;
        check("fim_ready", in_ready, 0);
        inicio = 1'b1; fim = 1'b1;
        @(posedge clk); #1;
        inicio = 1'b0; fim = 1'b0;
        mdl_ativo = 1; mdl_cnt = 0; mdl_erro = 0; mdl_cod = 2'd0; mdl_cheio = 0;
        check("inicio_wins", in_ready, 1);

        // random mix, including immediate boundaries
        for (int n = 0; n < 80; n++) begin
            if (!mdl_ativo) start();
            ro = 5'($urandom_range(0, 21));
            case ($urandom_range(0, 3))
                0: ri = 32'(int'($urandom_range(0, 128)) - 64) & ~32'd1;
                1: ri = $urandom;
                2: ri = 32'(bnd[$urandom_range(0, 11)]);
                default: ri = 32'(int'($urandom_range(0, 64)) - 32) | 32'd1;
            endcase
            send(ro, 5'($urandom), 5'($urandom), 5'($urandom), ri, ($urandom_range(0, 9) == 0));
        end

        // reset in the cycle after a transfer
        start();
        send(5'd2, 5'd4, 5'd5, 5'd6, 32'd0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mdl_ativo = 0;
        check_reset("rst_after");

        // reset on the same edge as an offered transfer: nothing is written
        start();
        op = 5'd0; rd = 5'd7; rs1 = 5'd8; rs2 = 5'd9; imm = 32'd0;
        in_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b0; mdl_ativo = 0;
        check_reset("rst_same");
        @(posedge clk); #1;
        check("rst_same_no_we", mem_we, 0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
